// File: rtl/instr_encoder_pkg.sv
// Shared types, opcodes and field packers for the instruction encoder.
// Kind enumeration order matches the req_kind wire encoding.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        K_LW    = 4'd0,
        K_SW    = 4'd1,
        K_RTYPE = 4'd2,
        K_BEQ   = 4'd3,
        K_ITYPE = 4'd4,
        K_JAL   = 4'd5,
        K_STALL = 4'd6,
        K_FLW   = 4'd7,
        K_FSW   = 4'd8,
        K_FPR   = 4'd9
    } kind_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_FSW   = 7'b0100111;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_FPR   = 7'b1010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] LW_F3  = 3'b010;
    localparam logic [2:0] BEQ_F3 = 3'b000;

    function automatic logic [31:0] enc_i(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [6:0]  op
    );
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(
        input logic [11:0] imm,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [6:0]  op
    );
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // off holds imm[12:1]; bit 0 is implicitly zero
    function automatic logic [31:0] enc_b(
        input logic [11:0] off,
        input logic [4:0]  rs2,
        input logic [4:0]  rs1,
        input logic [2:0]  f3,
        input logic [6:0]  op
    );
        return {off[11], off[9:4], rs2, rs1, f3,
                off[3:0], off[10], op};
    endfunction

    // off holds imm[20:1]
    function automatic logic [31:0] enc_j(
        input logic [19:0] off,
        input logic [4:0]  rd,
        input logic [6:0]  op
    );
        return {off[19], off[9:0], off[10], off[18:11], rd, op};
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [6:0] f7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] f3,
        input logic [4:0] rd,
        input logic [6:0] op
    );
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and encoded-word handshake bundle for instr_encoder.
// master = requester/consumer side, slave = encoder side.
interface instr_encoder_if #(
    parameter int DEPTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [3:0]               req_kind;
    logic [4:0]               req_rd;
    logic [4:0]               req_rs1;
    logic [4:0]               req_rs2;
    logic [2:0]               req_funct3;
    logic [6:0]               req_funct7;
    logic [31:0]              req_imm;
    logic [31:0]              instr;
    logic                     instr_valid;
    logic                     instr_ready;
    logic                     err;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output req_valid, req_kind, req_rd, req_rs1, req_rs2,
        output req_funct3, req_funct7, req_imm, instr_ready,
        input  req_ready, instr, instr_valid, err, level
    );

    modport slave (
        input  req_valid, req_kind, req_rd, req_rs1, req_rs2,
        input  req_funct3, req_funct7, req_imm, instr_ready,
        output req_ready, instr, instr_valid, err, level
    );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Circular output buffer for encoded words; power-of-two DEPTH.
// dout reads zero whenever the buffer is empty.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = (count != '0) ? mem[rd_ptr] : '0;
    assign valid = (count != '0);
    assign ready = (count < FULL);
    assign level = count;
endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder with range checking and an output FIFO.
// Define INSTR_ENCODER_FP_EN to enable the FLW/FSW/FPR encodings.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    instr_encoder_if.slave bus
);
    logic [31:0] imm;
    logic [31:0] word;
    logic        legal;
    logic        fit_i;
    logic        fit_b;
    logic        fit_j;
    logic        accept;
    logic        push;
    logic        err_q;

    assign imm = bus.req_imm;

    // a value fits when all bits above the field's sign bit match it
    assign fit_i = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign fit_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.req_kind)
            K_LW: begin
                legal = fit_i;
                word  = enc_i(imm[11:0], bus.req_rs1, LW_F3,
                              bus.req_rd, OP_LW);
            end
            K_ITYPE: begin
                legal = fit_i;
                word  = enc_i(imm[11:0], bus.req_rs1,
                              bus.req_funct3, bus.req_rd, OP_ITYPE);
            end
            K_SW: begin
                legal = fit_i;
                word  = enc_s(imm[11:0], bus.req_rs2, bus.req_rs1,
                              LW_F3, OP_SW);
            end
            K_BEQ: begin
                legal = fit_b;
                word  = enc_b(imm[12:1], bus.req_rs2, bus.req_rs1,
                              BEQ_F3, OP_BEQ);
            end
            K_JAL: begin
                legal = fit_j;
                word  = enc_j(imm[20:1], bus.req_rd, OP_JAL);
            end
            K_RTYPE: begin
                legal = 1'b1;
                word  = enc_r(bus.req_funct7, bus.req_rs2, bus.req_rs1,
                              bus.req_funct3, bus.req_rd, OP_RTYPE);
            end
            K_STALL: begin
                legal = 1'b1;
                word  = '0;
            end
`ifdef INSTR_ENCODER_FP_EN
            K_FLW: begin
                legal = fit_i;
                word  = enc_i(imm[11:0], bus.req_rs1, LW_F3,
                              bus.req_rd, OP_FLW);
            end
            K_FSW: begin
                legal = fit_i;
                word  = enc_s(imm[11:0], bus.req_rs2, bus.req_rs1,
                              LW_F3, OP_FSW);
            end
            K_FPR: begin
                legal = 1'b1;
                word  = enc_r(bus.req_funct7, bus.req_rs2, bus.req_rs1,
                              bus.req_funct3, bus.req_rd, OP_FPR);
            end
`else
`endif
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    // a request seen in the reset cycle is dropped, never queued
    assign accept = bus.req_valid & bus.req_ready & ~reset;
    assign push   = accept & legal;

    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= accept & ~legal;
    end

    assign bus.err = err_q;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (word),
        .pop   (bus.instr_ready),
        .dout  (bus.instr),
        .valid (bus.instr_valid),
        .ready (bus.req_ready),
        .level (bus.level)
    );
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output-buffer depth in instruction words; power of two, at least 2.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present; req_ready  out  1  request accepted when both are high at a clk edge.
REQ-005 req_kind  in  4  0=LW 1=SW 2=RTYPE 3=BEQ 4=ITYPE 5=JAL 6=STALL 7=FLW 8=FSW 9=FPR; 10-15 illegal.
REQ-006 req_rd, req_rs1, req_rs2  in  5 each  register fields.
REQ-007 req_funct3  in  3, req_funct7  in  7  function fields.
REQ-008 req_imm  in  32  signed byte-offset or immediate.
REQ-009 instr  out  32  encoded word at buffer head; instr_valid  out  1; instr_ready  in  1; a word pops when instr_valid and instr_ready are both high.
REQ-010 err  out  1  one-cycle pulse for a rejected request.
REQ-011 level  out  $clog2(DEPTH)+1  buffered word count.

Function
REQ-012 Opcodes SHALL be: LW 0000011, FLW 0000111, SW 0100011, FSW 0100111, RTYPE 0110011, FPR 1010011, BEQ 1100011, ITYPE 0010011, JAL 1101111.
REQ-013 LW, FLW and ITYPE SHALL use I-format with imm[11:0]; LW and FLW SHALL force funct3=010.
REQ-014 SW and FSW SHALL use S-format with funct3=010.
REQ-015 BEQ SHALL use B-format with funct3=000.
REQ-016 JAL SHALL use J-format.
REQ-017 RTYPE and FPR SHALL take funct7 and funct3 from the request.
REQ-018 STALL SHALL encode 32'h00000000.
REQ-019 Range checks: I/S imm SHALL fit signed 12 bits; B SHALL fit signed 13 bits with imm[0]=0; J SHALL fit signed 21 bits with imm[0]=0.
REQ-020 A failing range check or an illegal kind SHALL consume the request, pulse err the next cycle and enqueue nothing.
REQ-021 req_ready SHALL equal level<DEPTH; it SHALL NOT depend combinationally on instr_ready.
REQ-022 An accepted legal request SHALL be registered into the FIFO; with an empty FIFO it SHALL appear on instr with instr_valid=1 one cycle after acceptance.
REQ-023 instr_valid SHALL equal level!=0; instr SHALL be held stable while instr_valid=1 and instr_ready=0.
REQ-024 Words SHALL leave in acceptance order; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A simultaneous push and pop SHALL leave level unchanged.
REQ-026 A pop when empty and a push when full SHALL be ignored.

Reset
REQ-027 While reset is high at a clk edge: both pointers=0, level=0, err=0, instr_valid=0, req_ready=1, and instr SHALL read 0.
REQ-028 Reset asserted mid-stream SHALL discard all buffered words; a request presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-029 With macro INSTR_ENCODER_FP_EN defined, kinds FLW, FSW and FPR SHALL be encoded per REQ-012 to REQ-017.
REQ-030 Without INSTR_ENCODER_FP_EN, kinds 7-9 SHALL be treated as illegal per REQ-020, and no FP opcode logic SHALL be synthesized.

Structure
REQ-031 Package instr_enc_pkg SHALL hold the req_kind enumeration, the opcode constants and the funct3 constants LW_F3=010 and BEQ_F3=000.
REQ-032 Encoding and range checks SHALL be combinational in instr_encoder.
REQ-033 Buffering SHALL be a sub-module named instr_fifo, parameterized by DEPTH and WIDTH=32.

Verification
REQ-034 LW rd=5 rs1=2 imm=8 into an empty FIFO -> instr=0x00812283, instr_valid=1 the next cycle.
REQ-035 SW rs2=6 rs1=2 imm=12 -> 0x00612623; BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=2048 -> 0x001000EF.
REQ-036 ITYPE imm=2048 and BEQ imm=3 -> err pulses once each, level stays 0.
REQ-037 DEPTH=4 with instr_ready=0 and 5 requests offered -> 4 accepted, then req_ready=0; raise instr_ready -> the 4 words emerge in order, level reaches 0.
REQ-038 Push and pop in the same cycle at level=2 -> level stays 2; assert reset at level=3 -> level=0 and instr_valid=0 next cycle.
REQ-039 Without INSTR_ENCODER_FP_EN, FLW -> err pulse; with it, FLW rd=1 rs1=2 imm=0 -> 0x00012087.
